// File: rtl/run_ctrl_if.sv
// Host-side bus of run_ctrl: the run request, per-hart PC samples and the run status.
// The master drives start/pc/pc_valid; the controller (slave) returns status.
interface run_ctrl_if #(
  parameter int NUM_HARTS = 1,
  parameter int PC_W      = 32,
  parameter int CNT_W     = 16
);
  logic                      start;
  logic [NUM_HARTS*PC_W-1:0] pc;
  logic [NUM_HARTS-1:0]      pc_valid;
  logic                      core_rst;
  logic                      running;
  logic                      done;
  logic                      timeout;
  logic [NUM_HARTS-1:0]      halted;
  logic [CNT_W-1:0]          cycle_cnt;

  modport master (
    output start, pc, pc_valid,
    input  core_rst, running, done, timeout, halted, cycle_cnt
  );

  modport slave (
    input  start, pc, pc_valid,
    output core_rst, running, done, timeout, halted, cycle_cnt
  );
endinterface

// File: rtl/run_ctrl.sv
// Run controller: core reset sequencing, bounded run, per-hart PC self-loop halt detect, drain, done.
// Define RUN_CTRL_HALT_DETECT_EN to build the halt trackers; otherwise every run ends on the budget.
module run_ctrl #(
  parameter int NUM_HARTS    = 1,
  parameter int PC_W         = 32,
  parameter int RST_CYCLES   = 5,
  parameter int MAX_CYCLES   = 64,
  parameter int STALL_CYCLES = 4,
  parameter int DRAIN_CYCLES = 5,
  parameter int CNT_W        = 16
) (
  input logic       clk,
  input logic       reset,
  run_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RESET = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int PH_MAX = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  logic [2:0]           r_state, w_state_nxt;
  logic [PH_W-1:0]      r_phase_cnt, w_phase_nxt;
  logic [CNT_W-1:0]     r_cycle_cnt, w_cycle_nxt, w_cycle_inc;
  logic                 r_timeout, w_timeout_nxt;
  logic [NUM_HARTS-1:0] r_halted, w_halted_nxt;
  logic                 r_core_rst, r_running, r_done;
  logic                 w_start_ok;

  assign w_start_ok  = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.start;
  assign w_cycle_inc = r_cycle_cnt + CNT_W'(1);

`ifdef RUN_CTRL_HALT_DETECT_EN
  localparam int SC_W = $clog2(STALL_CYCLES + 1);

  logic [PC_W-1:0]      r_last_pc  [NUM_HARTS];
  logic [SC_W-1:0]      r_same_cnt [NUM_HARTS];
  logic [NUM_HARTS-1:0] r_seen;
  logic [PC_W-1:0]      w_last_nxt [NUM_HARTS];
  logic [SC_W-1:0]      w_same_nxt [NUM_HARTS];
  logic [NUM_HARTS-1:0] w_seen_nxt;

  // The first valid sample of a run only primes last_pc; later matching samples count repeats.
  always_comb begin
    w_seen_nxt   = r_seen;
    w_halted_nxt = r_halted;
    for (int h = 0; h < NUM_HARTS; h++) begin
      w_last_nxt[h] = r_last_pc[h];
      w_same_nxt[h] = r_same_cnt[h];
      if ((r_state == S_RUN) && bus.pc_valid[h]) begin
        if (!r_seen[h]) begin
          w_seen_nxt[h] = 1'b1;
          w_last_nxt[h] = bus.pc[h*PC_W +: PC_W];
          w_same_nxt[h] = '0;
        end else if (bus.pc[h*PC_W +: PC_W] == r_last_pc[h]) begin
          if (r_same_cnt[h] != SC_W'(STALL_CYCLES))
            w_same_nxt[h] = r_same_cnt[h] + SC_W'(1);
          if (r_same_cnt[h] >= SC_W'(STALL_CYCLES - 1))
            w_halted_nxt[h] = 1'b1;
        end else begin
          w_last_nxt[h] = bus.pc[h*PC_W +: PC_W];
          w_same_nxt[h] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seen <= '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
        r_last_pc[h]  <= '0;
        r_same_cnt[h] <= '0;
      end
    end else if (w_start_ok) begin
      r_seen <= '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
        r_last_pc[h]  <= '0;
        r_same_cnt[h] <= '0;
      end
    end else begin
      r_seen <= w_seen_nxt;
      for (int h = 0; h < NUM_HARTS; h++) begin
        r_last_pc[h]  <= w_last_nxt[h];
        r_same_cnt[h] <= w_same_nxt[h];
      end
    end
  end
`else
  logic w_unused_pc;

  assign w_unused_pc  = ^{bus.pc, bus.pc_valid};
  assign w_halted_nxt = '0;
`endif

  // A halt registered on an earlier edge wins outright; on the budget edge a
  // same-edge halt still clears timeout, so halt beats budget in a tie.
  always_comb begin
    w_state_nxt   = r_state;
    w_phase_nxt   = r_phase_cnt;
    w_cycle_nxt   = r_cycle_cnt;
    w_timeout_nxt = r_timeout;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_state_nxt   = S_RESET;
          w_phase_nxt   = '0;
          w_cycle_nxt   = '0;
          w_timeout_nxt = 1'b0;
        end
      end
      S_RESET: begin
        if (r_phase_cnt == PH_W'(RST_CYCLES - 1)) begin
          w_state_nxt = S_RUN;
          w_phase_nxt = '0;
        end else begin
          w_phase_nxt = r_phase_cnt + PH_W'(1);
        end
      end
      S_RUN: begin
        w_cycle_nxt = w_cycle_inc;
        if (&r_halted) begin
          w_state_nxt   = S_DRAIN;
          w_phase_nxt   = '0;
          w_timeout_nxt = 1'b0;
        end else if (w_cycle_inc == CNT_W'(MAX_CYCLES)) begin
          w_state_nxt   = S_DRAIN;
          w_phase_nxt   = '0;
          w_timeout_nxt = ~&w_halted_nxt;
        end
      end
      S_DRAIN: begin
        if (r_phase_cnt == PH_W'(DRAIN_CYCLES - 1)) begin
          w_state_nxt = S_DONE;
          w_phase_nxt = '0;
        end else begin
          w_phase_nxt = r_phase_cnt + PH_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they change on the entering edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_phase_cnt <= '0;
      r_cycle_cnt <= '0;
      r_timeout   <= 1'b0;
      r_halted    <= '0;
      r_core_rst  <= 1'b1;
      r_running   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase_cnt <= w_phase_nxt;
      r_cycle_cnt <= w_cycle_nxt;
      r_timeout   <= w_timeout_nxt;
      r_halted    <= w_start_ok ? '0 : w_halted_nxt;
      r_core_rst  <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_RESET) ||
                     (w_state_nxt == S_DONE);
      r_running   <= (w_state_nxt == S_RUN);
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.core_rst  = r_core_rst;
  assign bus.running   = r_running;
  assign bus.done      = r_done;
  assign bus.timeout   = r_timeout;
  assign bus.halted    = r_halted;
  assign bus.cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl with two harts and default budgets.
// Halt scenarios build only when RUN_CTRL_HALT_DETECT_EN is defined.
module tb_run_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  run_ctrl_if #(.NUM_HARTS(2), .PC_W(32), .CNT_W(16)) bus ();

  run_ctrl #(
    .NUM_HARTS(2), .PC_W(32), .RST_CYCLES(5), .MAX_CYCLES(64),
    .STALL_CYCLES(4), .DRAIN_CYCLES(5), .CNT_W(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic count_reset_cycles(output int n);
    n = 0;
    while (bus.core_rst && !bus.running && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic count_drain_cycles(output int n);
    n = 0;
    while (!bus.done && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic drive_inc_pc(input int c);
    bus.pc_valid = 2'b11;
    bus.pc       = {32'h2000 + 4*c, 32'h1000 + 4*c};
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.core_rst !== 1'b1 || bus.running !== 1'b0 || bus.done !== 1'b0 ||
        bus.timeout !== 1'b0 || bus.halted !== 2'b00 || bus.cycle_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_values: got rst=%b run=%b done=%b to=%b h=%b cnt=%0d expected 1 0 0 0 00 0",
               bus.core_rst, bus.running, bus.done, bus.timeout, bus.halted, bus.cycle_cnt);
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (bus.core_rst !== 1'b1 || bus.running !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_hold: got rst=%b run=%b done=%b expected 1 0 0",
               bus.core_rst, bus.running, bus.done);
    end
  endtask

  task automatic test_budget_run();
    int n;
    pulse_start();
    count_reset_cycles(n);
    checks++;
    if (n != 5) begin
      errors++;
      $display("[TB] FAIL budget_reset_len: got %0d expected 5", n);
    end
    checks++;
    if (bus.running !== 1'b1 || bus.core_rst !== 1'b0 || bus.cycle_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL budget_run_entry: got run=%b rst=%b cnt=%0d expected 1 0 0",
               bus.running, bus.core_rst, bus.cycle_cnt);
    end
    n = 0;
    while (bus.running && n < 200) begin
      drive_inc_pc(n + 1);
      tick();
      n++;
    end
    checks++;
    if (n != 64) begin
      errors++;
      $display("[TB] FAIL budget_run_len: got %0d expected 64", n);
    end
    checks++;
    if (bus.cycle_cnt !== 16'd64 || bus.core_rst !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL budget_drain_entry: got cnt=%0d rst=%b done=%b expected 64 0 0",
               bus.cycle_cnt, bus.core_rst, bus.done);
    end
    count_drain_cycles(n);
    checks++;
    if (n != 5) begin
      errors++;
      $display("[TB] FAIL budget_drain_len: got %0d expected 5", n);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (bus.done !== 1'b1 || bus.timeout !== 1'b1 || bus.cycle_cnt !== 16'd64 ||
        bus.core_rst !== 1'b1 || bus.halted !== 2'b00) begin
      errors++;
      $display("[TB] FAIL budget_done: got done=%b to=%b cnt=%0d rst=%b h=%b expected 1 1 64 1 00",
               bus.done, bus.timeout, bus.cycle_cnt, bus.core_rst, bus.halted);
    end
  endtask

`ifdef RUN_CTRL_HALT_DETECT_EN
  task automatic test_halt();
    int n;
    int c;
    pulse_start();
    count_reset_cycles(n);
    c = 1;
    while (bus.running && c <= 100) begin
      bus.pc_valid = 2'b11;
      bus.pc[31:0]  = (c >= 10) ? 32'h40 : 32'h1000 + 4*c;
      bus.pc[63:32] = (c >= 20) ? 32'h80 : 32'h2000 + 4*c;
      tick();
      if (c == 13) begin
        checks++;
        if (bus.halted !== 2'b00) begin
          errors++;
          $display("[TB] FAIL halt_c13: got %b expected 00", bus.halted);
        end
      end
      if (c == 14) begin
        checks++;
        if (bus.halted !== 2'b01) begin
          errors++;
          $display("[TB] FAIL halt_c14: got %b expected 01", bus.halted);
        end
      end
      if (c == 24) begin
        checks++;
        if (bus.halted !== 2'b11 || bus.running !== 1'b1) begin
          errors++;
          $display("[TB] FAIL halt_c24: got h=%b run=%b expected 11 1", bus.halted, bus.running);
        end
      end
      c++;
    end
    checks++;
    if (c - 1 != 25 || bus.cycle_cnt !== 16'd25) begin
      errors++;
      $display("[TB] FAIL halt_run_len: got cycles=%0d cnt=%0d expected 25 25", c - 1, bus.cycle_cnt);
    end
    count_drain_cycles(n);
    checks++;
    if (n != 5 || bus.timeout !== 1'b0 || bus.halted !== 2'b11 || bus.cycle_cnt !== 16'd25) begin
      errors++;
      $display("[TB] FAIL halt_done: got drain=%0d to=%b h=%b cnt=%0d expected 5 0 11 25",
               n, bus.timeout, bus.halted, bus.cycle_cnt);
    end
  endtask

  task automatic test_tie_and_qualifier();
    int n;
    int c;
    pulse_start();
    count_reset_cycles(n);
    c = 1;
    while (bus.running && c <= 100) begin
      bus.pc_valid[0] = !(c == 12 || c == 13);
      bus.pc_valid[1] = 1'b1;
      bus.pc[31:0]  = (c == 12 || c == 13) ? 32'hdead : (c >= 10) ? 32'h40 : 32'h1000 + 4*c;
      bus.pc[63:32] = (c >= 60) ? 32'h80 : 32'h2000 + 4*c;
      tick();
      if (c == 15) begin
        checks++;
        if (bus.halted !== 2'b00) begin
          errors++;
          $display("[TB] FAIL qual_c15: got %b expected 00", bus.halted);
        end
      end
      if (c == 16) begin
        checks++;
        if (bus.halted !== 2'b01) begin
          errors++;
          $display("[TB] FAIL qual_c16: got %b expected 01", bus.halted);
        end
      end
      c++;
    end
    checks++;
    if (c - 1 != 64 || bus.cycle_cnt !== 16'd64 || bus.halted !== 2'b11) begin
      errors++;
      $display("[TB] FAIL tie_run_len: got cycles=%0d cnt=%0d h=%b expected 64 64 11",
               c - 1, bus.cycle_cnt, bus.halted);
    end
    count_drain_cycles(n);
    checks++;
    if (n != 5 || bus.timeout !== 1'b0 || bus.done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL tie_done: got drain=%0d to=%b done=%b expected 5 0 1", n, bus.timeout, bus.done);
    end
  endtask
`else
  task automatic test_no_halt_detect();
    int n;
    int c;
    pulse_start();
    count_reset_cycles(n);
    c = 1;
    while (bus.running && c <= 100) begin
      bus.pc_valid = 2'b11;
      bus.pc       = {32'h80, 32'h40};
      tick();
      if (c == 10) begin
        checks++;
        if (bus.halted !== 2'b00) begin
          errors++;
          $display("[TB] FAIL nohalt_c10: got %b expected 00", bus.halted);
        end
      end
      c++;
    end
    checks++;
    if (c - 1 != 64 || bus.cycle_cnt !== 16'd64) begin
      errors++;
      $display("[TB] FAIL nohalt_run_len: got cycles=%0d cnt=%0d expected 64 64", c - 1, bus.cycle_cnt);
    end
    count_drain_cycles(n);
    checks++;
    if (n != 5 || bus.timeout !== 1'b1 || bus.halted !== 2'b00) begin
      errors++;
      $display("[TB] FAIL nohalt_done: got drain=%0d to=%b h=%b expected 5 1 00", n, bus.timeout, bus.halted);
    end
  endtask
`endif

  task automatic test_rerun_ignore_start();
    int n;
    pulse_start();
    checks++;
    if (bus.done !== 1'b0 || bus.timeout !== 1'b0 || bus.halted !== 2'b00 ||
        bus.cycle_cnt !== 16'd0 || bus.core_rst !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rerun_clear: got done=%b to=%b h=%b cnt=%0d rst=%b expected 0 0 00 0 1",
               bus.done, bus.timeout, bus.halted, bus.cycle_cnt, bus.core_rst);
    end
    tick();
    pulse_start();
    count_reset_cycles(n);
    checks++;
    if (n != 3 || bus.running !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ignore_in_reset: got remaining=%0d run=%b expected 3 1", n, bus.running);
    end
    n = 0;
    while (bus.running && n < 200) begin
      drive_inc_pc(n + 1);
      bus.start = (n == 10);
      tick();
      n++;
    end
    bus.start = 1'b0;
    checks++;
    if (n != 64) begin
      errors++;
      $display("[TB] FAIL ignore_in_run: got run cycles %0d expected 64", n);
    end
    n = 0;
    while (!bus.done && n < 50) begin
      bus.start = (n == 2);
      tick();
      n++;
    end
    bus.start = 1'b0;
    checks++;
    if (n != 5 || bus.timeout !== 1'b1 || bus.cycle_cnt !== 16'd64) begin
      errors++;
      $display("[TB] FAIL ignore_in_drain: got drain=%0d to=%b cnt=%0d expected 5 1 64",
               n, bus.timeout, bus.cycle_cnt);
    end
  endtask

  task automatic test_abort();
    int n;
    pulse_start();
    count_reset_cycles(n);
    for (int c = 1; c < 30; c++) begin
      drive_inc_pc(c);
      tick();
    end
    checks++;
    if (bus.cycle_cnt !== 16'd29 || bus.running !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_pre: got cnt=%0d run=%b expected 29 1", bus.cycle_cnt, bus.running);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.core_rst !== 1'b1 || bus.running !== 1'b0 || bus.cycle_cnt !== 16'd0 ||
        bus.done !== 1'b0 || bus.timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_same_cycle: got rst=%b run=%b cnt=%0d done=%b to=%b expected 1 0 0 0 0",
               bus.core_rst, bus.running, bus.cycle_cnt, bus.done, bus.timeout);
    end
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (bus.core_rst !== 1'b1 || bus.running !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_idle: got rst=%b run=%b done=%b expected 1 0 0",
               bus.core_rst, bus.running, bus.done);
    end
    pulse_start();
    count_reset_cycles(n);
    n = 0;
    while (bus.running && n < 200) begin
      drive_inc_pc(n + 1);
      tick();
      n++;
    end
    checks++;
    if (n != 64) begin
      errors++;
      $display("[TB] FAIL abort_rerun_len: got %0d expected 64", n);
    end
    count_drain_cycles(n);
    checks++;
    if (n != 5 || bus.timeout !== 1'b1 || bus.cycle_cnt !== 16'd64) begin
      errors++;
      $display("[TB] FAIL abort_rerun_done: got drain=%0d to=%b cnt=%0d expected 5 1 64",
               n, bus.timeout, bus.cycle_cnt);
    end
  endtask

  initial begin
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.pc       = '0;
    bus.pc_valid = '0;
    test_reset();
    test_budget_run();
`ifdef RUN_CTRL_HALT_DETECT_EN
    test_halt();
    test_tie_and_qualifier();
`else
    test_no_halt_detect();
`endif
    test_rerun_ignore_start();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
